// File: rtl/mmbus_pkg.sv
// Shared types and constants for the mmbus address-decoding bus bridge.
// FSM state encoding, fault-cause codes and the slave-index width helper.
package mmbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef logic [1:0] err_cause_t;

    localparam err_cause_t ERR_NONE     = 2'b00;
    localparam err_cause_t ERR_UNMAPPED = 2'b01;
    localparam err_cause_t ERR_TIMEOUT  = 2'b10;

    // Index width for n slaves; a single slave still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmbus_if.sv
// Bus bundle between the CPU memory port, the mmbus bridge and its slaves.
// master = CPU side; slave = the bridge as seen by the CPU (it also drives the slave-side fan-out).
interface mmbus_if #(
    parameter int N_SLV = 8
);

    logic [31:0]         m_a;
    logic [31:0]         m_d;
    logic                m_we;
    logic                m_rd;
    logic [31:0]         m_spo;
    logic                m_ready;
    logic                m_err;

    logic [31:0]         s_a;
    logic [31:0]         s_d;
    logic [N_SLV-1:0]    s_we;
    logic [N_SLV-1:0]    s_rd;
    logic [32*N_SLV-1:0] s_spo;
    logic [N_SLV-1:0]    s_ready;

    modport master (
        output m_a, m_d, m_we, m_rd,
        input  m_spo, m_ready, m_err
    );

    modport slave (
        input  m_a, m_d, m_we, m_rd, s_spo, s_ready,
        output m_spo, m_ready, m_err, s_a, s_d, s_we, s_rd
    );

endinterface

// File: rtl/mmbus_decode.sv
// Combinational base/mask address decoder with priority encoding.
// The lowest-numbered matching slave wins when ranges overlap.
module mmbus_decode
    import mmbus_pkg::*;
#(
    parameter int                  N_SLV    = 8,
    parameter logic [32*N_SLV-1:0] SLV_BASE = {N_SLV{32'h0}},
    parameter logic [32*N_SLV-1:0] SLV_MASK = {N_SLV{32'hf000_0000}},
    parameter int                  SEL_W    = sel_width(N_SLV)
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [SEL_W-1:0] sel
);

    // Scan from the top down so the lowest match is the last one written.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hit = 1'b0;
        sel = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmbus.sv
// Registered bus bridge: decodes CPU requests onto N slave ports with fault capture.
// Build option: define MMBUS_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles.
module mmbus
    import mmbus_pkg::*;
#(
    parameter int                  N_SLV       = 8,
    parameter logic [32*N_SLV-1:0] SLV_BASE    = {N_SLV{32'h0}},
    parameter logic [32*N_SLV-1:0] SLV_MASK    = {N_SLV{32'hf000_0000}},
    parameter int                  TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         rst,
    mmbus_if.slave       bus,
    input  logic         err_clr,
    output logic         err_valid,
    output logic [31:0]  err_addr,
    output err_cause_t   err_cause
);

    localparam int SEL_W = sel_width(N_SLV);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] sel, dec_sel;
    logic             dec_hit;
    logic             op_we;
    logic             fault;
    logic [31:0]      s_a_q, s_d_q, spo_q, spo_sel;
    logic [N_SLV-1:0] strobe;
    logic             ready_sel;
    logic             req, timeout, fault_now;

    assign req = bus.m_we | bus.m_rd;

    mmbus_decode #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .SEL_W    (SEL_W)
    ) u_decode (
        .addr (bus.m_a),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    always_comb begin
        ready_sel = 1'b0;
        spo_sel   = '0;
        strobe    = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel == SEL_W'(i)) begin
                ready_sel = bus.s_ready[i];
                spo_sel   = bus.s_spo[32*i +: 32];
                strobe[i] = 1'b1;
            end
        end
    end

`ifdef MMBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Held at zero outside WAIT, so it restarts on every entry.
    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT) wait_cnt <= '0;
        else                         wait_cnt <= wait_cnt + 1'b1;
    end

    // wait_cnt counts the WAIT cycles before this one; a ready slave still wins.
    assign timeout = (state == ST_WAIT) && !ready_sel &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    assign fault_now = ((state == ST_IDLE) && req && !dec_hit) || timeout;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.m_ready = 1'b0;
        bus.m_err   = 1'b0;
        bus.s_we    = '0;
        bus.s_rd    = '0;
        case (state)
            ST_IDLE: begin
                bus.m_ready = ~req;
                if (req) state_nxt = dec_hit ? ST_ISSUE : ST_DONE;
            end
            ST_ISSUE: begin
                if (op_we) bus.s_we = strobe;
                else       bus.s_rd = strobe;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (ready_sel || timeout) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.m_ready = 1'b1;
                bus.m_err   = fault;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            s_a_q     <= '0;
            s_d_q     <= '0;
            spo_q     <= '0;
            op_we     <= 1'b0;
            sel       <= '0;
            fault     <= 1'b0;
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_cause <= ERR_NONE;
        end else begin
            if (state == ST_IDLE && req) begin
                s_a_q <= bus.m_a;
                s_d_q <= bus.m_d;
                op_we <= bus.m_we;
                sel   <= dec_sel;
                fault <= ~dec_hit;
                if (!dec_hit) spo_q <= '0;
            end
            if (state == ST_WAIT) begin
                if (ready_sel) begin
                    spo_q <= spo_sel;
                end else if (timeout) begin
                    spo_q <= '0;
                    fault <= 1'b1;
                end
            end
            // First fault sticks; a clear in the same cycle lets the new fault in.
            if (fault_now && (!err_valid || err_clr)) begin
                err_valid <= 1'b1;
                err_addr  <= timeout ? s_a_q : bus.m_a;
                err_cause <= timeout ? ERR_TIMEOUT : ERR_UNMAPPED;
            end else if (err_clr) begin
                err_valid <= 1'b0;
                err_addr  <= '0;
                err_cause <= ERR_NONE;
            end
        end
    end

    assign bus.s_a   = s_a_q;
    assign bus.s_d   = s_d_q;
    assign bus.m_spo = spo_q;

endmodule

// File: tb/tb_mmbus.sv
// Directed bench for mmbus: vector table of single transfers plus fault, timeout and reset sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mmbus;
    import mmbus_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;
    localparam logic [32*N-1:0] BASE = {32'h8000_0000, 32'h9000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [32*N-1:0] MASK = {32'hc000_0000, 32'hf000_0000, 32'hf000_0000, 32'hf000_0000};
    localparam logic [32*N-1:0] SPO  = {32'h3333_f00d, 32'h2222_beef, 32'h1234_5678, 32'hc0de_0000};
    localparam int LIMIT = 1100;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic        rd;
        logic        mapped;
        int          sel;
        int          delay;
        int          lat;
        logic [31:0] spo;
        logic        err;
    } vec_t;

    logic        clk, rst, err_clr, err_valid;
    logic [31:0] err_addr;
    err_cause_t  err_cause;
    int          n_vec, n_miss;
    vec_t        vecs[6];
    vec_t        v_tmp;

    mmbus_if #(.N_SLV(N)) bus();

    mmbus #(
        .N_SLV       (N),
        .SLV_BASE    (BASE),
        .SLV_MASK    (MASK),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_clr   (err_clr),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .err_cause (err_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Starts at a falling edge with the bridge idle; ends one cycle after completion.
    task automatic run_xfer(input string tag, input vec_t v);
        int         k;
        int         extra;
        logic       done;
        logic [N-1:0] exp_we, exp_rd;
        exp_we = '0;
        exp_rd = '0;
        if (v.mapped) begin
            if (v.we) exp_we[v.sel] = 1'b1;
            else      exp_rd[v.sel] = 1'b1;
        end
        bus.m_a     = v.addr;
        bus.m_d     = v.data;
        bus.m_we    = v.we;
        bus.m_rd    = v.rd;
        bus.s_ready = '0;
        #1 check({tag, " req_ready"}, 64'(bus.m_ready), 64'(0));
        @(negedge clk);
        bus.m_we = 1'b0;
        bus.m_rd = 1'b0;
        err_clr  = 1'b0;
        check({tag, " s_we"}, 64'(bus.s_we), 64'(exp_we));
        check({tag, " s_rd"}, 64'(bus.s_rd), 64'(exp_rd));
        if (v.mapped) begin
            check({tag, " s_a"}, 64'(bus.s_a), 64'(v.addr));
            check({tag, " s_d"}, 64'(bus.s_d), 64'(v.data));
        end
        k     = 1;
        extra = 0;
        done  = 1'b0;
        while (!done) begin
            if (bus.m_ready || k >= LIMIT) begin
                done = 1'b1;
            end else begin
                if (k >= 2 && ((|bus.s_we) || (|bus.s_rd))) extra++;
                bus.s_ready = (k >= 2 + v.delay) ? '1 : '0;
                @(negedge clk);
                k++;
            end
        end
        check({tag, " latency"}, 64'(k), 64'(v.lat));
        check({tag, " m_spo"}, 64'(bus.m_spo), 64'(v.spo));
        check({tag, " m_err"}, 64'(bus.m_err), 64'(v.err));
        check({tag, " extra_strobes"}, 64'(extra), 64'(0));
        bus.s_ready = '0;
        @(negedge clk);
        check({tag, " err_pulse_end"}, 64'(bus.m_err), 64'(0));
        check({tag, " back_idle"}, 64'(bus.m_ready), 64'(1));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst         = 1'b1;
        err_clr     = 1'b0;
        bus.m_a     = '0;
        bus.m_d     = '0;
        bus.m_we    = 1'b0;
        bus.m_rd    = 1'b0;
        bus.s_spo   = SPO;
        bus.s_ready = '0;

        vecs[0] = '{addr:32'h1000_0000, data:32'h0,         we:1'b0, rd:1'b1, mapped:1'b1, sel:1, delay:0,
                    lat:3, spo:32'h1234_5678, err:1'b0};
        vecs[1] = '{addr:32'h9200_0004, data:32'ha5a5_a5a5, we:1'b1, rd:1'b0, mapped:1'b1, sel:2, delay:4,
                    lat:7, spo:32'h2222_beef, err:1'b0};
        vecs[2] = '{addr:32'hb000_0010, data:32'h0,         we:1'b0, rd:1'b1, mapped:1'b1, sel:3, delay:1,
                    lat:4, spo:32'h3333_f00d, err:1'b0};
        vecs[3] = '{addr:32'h0000_0040, data:32'h0,         we:1'b0, rd:1'b1, mapped:1'b1, sel:0, delay:2,
                    lat:5, spo:32'hc0de_0000, err:1'b0};
        vecs[4] = '{addr:32'h1000_0008, data:32'h0000_0005, we:1'b1, rd:1'b1, mapped:1'b1, sel:1, delay:0,
                    lat:3, spo:32'h1234_5678, err:1'b0};
        vecs[5] = '{addr:32'h7000_0000, data:32'h0,         we:1'b0, rd:1'b1, mapped:1'b0, sel:0, delay:0,
                    lat:1, spo:32'h0,         err:1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst m_ready", 64'(bus.m_ready), 64'(1));
        check("rst m_spo", 64'(bus.m_spo), 64'(0));
        check("rst m_err", 64'(bus.m_err), 64'(0));
        check("rst s_a", 64'(bus.s_a), 64'(0));
        check("rst s_d", 64'(bus.s_d), 64'(0));
        check("rst s_we", 64'(bus.s_we), 64'(0));
        check("rst s_rd", 64'(bus.s_rd), 64'(0));
        check("rst err_valid", 64'(err_valid), 64'(0));
        check("rst err_addr", 64'(err_addr), 64'(0));
        check("rst err_cause", 64'(err_cause), 64'(ERR_NONE));

        for (int i = 0; i < 6; i++) run_xfer($sformatf("vec%0d", i), vecs[i]);

        check("cap valid", 64'(err_valid), 64'(1));
        check("cap addr", 64'(err_addr), 64'(32'h7000_0000));
        check("cap cause", 64'(err_cause), 64'(ERR_UNMAPPED));

        // A second fault pulses m_err but leaves the capture alone.
        v_tmp      = vecs[5];
        v_tmp.addr = 32'h7100_0000;
        run_xfer("fault2", v_tmp);
        check("fault2 addr kept", 64'(err_addr), 64'(32'h7000_0000));

        // Clear in the same cycle as a new fault: the new fault wins.
        err_clr    = 1'b1;
        v_tmp.addr = 32'h7200_0000;
        run_xfer("clr+fault", v_tmp);
        check("clr+fault valid", 64'(err_valid), 64'(1));
        check("clr+fault addr", 64'(err_addr), 64'(32'h7200_0000));
        check("clr+fault cause", 64'(err_cause), 64'(ERR_UNMAPPED));

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr valid", 64'(err_valid), 64'(0));
        check("clr addr", 64'(err_addr), 64'(0));
        check("clr cause", 64'(err_cause), 64'(ERR_NONE));

`ifdef MMBUS_TIMEOUT_EN
        // Ready on the last allowed WAIT cycle still completes normally.
        v_tmp       = vecs[0];
        v_tmp.delay = TO - 1;
        v_tmp.lat   = 2 + TO;
        run_xfer("to_edge", v_tmp);
        check("to_edge valid", 64'(err_valid), 64'(0));
        v_tmp.delay = 1000;
        v_tmp.spo   = 32'h0;
        v_tmp.err   = 1'b1;
        run_xfer("timeout", v_tmp);
        check("timeout valid", 64'(err_valid), 64'(1));
        check("timeout addr", 64'(err_addr), 64'(32'h1000_0000));
        check("timeout cause", 64'(err_cause), 64'(ERR_TIMEOUT));
`else
        v_tmp       = vecs[0];
        v_tmp.delay = 1000;
        v_tmp.lat   = 1003;
        run_xfer("long_wait", v_tmp);
        check("long_wait valid", 64'(err_valid), 64'(0));
`endif

        // Reset in the middle of WAIT drops the transfer and the capture.
        run_xfer("prefault", vecs[5]);
        check("prefault valid", 64'(err_valid), 64'(1));
        bus.m_a     = 32'h1000_0000;
        bus.m_rd    = 1'b1;
        bus.s_ready = '0;
        @(negedge clk);
        bus.m_rd = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wrst m_ready", 64'(bus.m_ready), 64'(1));
        check("wrst s_we", 64'(bus.s_we), 64'(0));
        check("wrst s_rd", 64'(bus.s_rd), 64'(0));
        check("wrst m_err", 64'(bus.m_err), 64'(0));
        check("wrst err_valid", 64'(err_valid), 64'(0));
        check("wrst err_addr", 64'(err_addr), 64'(0));
        @(negedge clk);
        check("wrst stays idle", 64'(bus.m_ready), 64'(1));
        check("wrst no err", 64'(bus.m_err), 64'(0));
        run_xfer("recover", vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mmbus.md
# mmbus

Parametrised, registered successor to the combinational address mapper. It sits between the CPU memory port and N slave devices, and decodes each request against per-slave base/mask pairs. Each request becomes a single-cycle strobe to the selected slave, then the block waits for that slave's ready. Unmapped accesses and hung slaves are reported through an error pulse and a sticky fault-capture register.

## Interface
- N_SLV, 8: number of slave ports (1..16).
- SLV_BASE, {N_SLV{32'h0}}: flattened 32·N_SLV base addresses; slave i is bits [32i+31:32i].
- SLV_MASK, {N_SLV{32'hf0000000}}: flattened decode masks. Slave i matches when (m_a & MASK_i) == BASE_i.
- TIMEOUT_CYC, 1023: maximum number of WAIT cycles before abort (≥1).
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- m_a  in  32  master address; held stable until m_ready.
- m_d  in  32  master write data; held stable until m_ready.
- m_we  in  1  write request, one-cycle pulse.
- m_rd  in  1  read request, one-cycle pulse.
- m_spo  out  32  read data; valid while m_ready is high after a request.
- m_ready  out  1  transfer-complete / idle indicator.
- m_err  out  1  one-cycle pulse on a faulted transfer (replaces irq).
- s_a  out  32  latched address, broadcast to all slaves.
- s_d  out  32  latched write data, broadcast to all slaves.
- s_we  out  N_SLV  per-slave write strobe.
- s_rd  out  N_SLV  per-slave read strobe.
- s_spo  in  32·N_SLV  flattened per-slave read data.
- s_ready  in  N_SLV  per-slave ready.
- err_valid  out  1  sticky: a fault has been captured.
- err_addr  out  32  address of the first captured fault.
- err_cause  out  2  fault cause: 01 = unmapped, 10 = timeout.
- err_clr  in  1  clears err_valid, err_addr and err_cause.

## Operation
- States are IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - m_ready = ~(m_we|m_rd), computed combinationally.
  - On a request, latch m_a/m_d and the operation, and latch the decoded slave index.
  - Lowest matching index wins when decode ranges overlap.
  - If both m_we and m_rd are high, the access is a write and the slave's rd strobe stays 0.
  - If no slave matches: go to DONE with the unmapped flag set.
  - Otherwise go to ISSUE.
- ISSUE:
  - Assert exactly one of s_we[sel] or s_rd[sel] for this one cycle; all other strobes stay 0.
  - Go to WAIT.
- WAIT:
  - Sample s_ready[sel]. When it is high, register s_spo[sel] into m_spo and go to DONE.
  - Timeout counter: see Configuration.
- DONE:
  - m_ready = 1 for one cycle, then return to IDLE.
  - On a fault, m_spo = 0 and m_err = 1.
- Requests arriving in ISSUE, WAIT or DONE are ignored; this is a master protocol violation.
- Fault capture:
  - A fault sets err_valid/err_addr/err_cause only when err_valid is 0.
  - Later faults still pulse m_err but do not overwrite the capture.
  - If err_clr and a new fault occur in the same cycle, the new fault is captured.
- s_a and s_d hold their last latched value between transfers.

## Timing
- Reset values:
  - State = IDLE; m_ready = 1.
  - m_spo = 0, m_err = 0, s_a = 0, s_d = 0, s_we = 0, s_rd = 0.
  - err_valid = 0, err_addr = 0, err_cause = 0, timeout counter = 0.
- Mapped access, request at cycle c0: ISSUE at c1, WAIT at c2. The earliest completion has m_ready high with data at c3 (3-cycle minimum).
- Each extra cycle of s_ready low adds one cycle of latency.
- Unmapped access, request at c0: DONE at c1.
- Reset asserted in any state:
  - Next cycle is IDLE with all strobes 0.
  - The in-flight transfer is dropped without an m_err pulse.
  - The captured fault is cleared.

## Configuration
- MMBUS_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches TIMEOUT_CYC with s_ready low, go to DONE with cause 10.
  - If s_ready is high in that same cycle, the transfer completes normally.
- MMBUS_TIMEOUT_EN undefined: there is no counter, WAIT lasts indefinitely, and cause 10 never occurs.

## Structure
- Package mmbus_pkg holds:
  - the state encoding;
  - the cause constants ERR_NONE=2'b00, ERR_UNMAPPED=2'b01, ERR_TIMEOUT=2'b10.
- Sub-module mmbus_decode: combinational base/mask match plus a priority encoder. It outputs hit and sel index for a given address.

## Test plan
- Read from slave 1 (base 0x10000000, mask 0xf0000000) with s_ready held at 1 and s_spo=0x12345678 → s_rd[1] pulses at c1 and m_ready=1 with m_spo=0x12345678 at c3.
- Write 0xA5A5A5A5 to 0x92000004 with slave ready delayed 4 cycles → single s_we pulse, s_d=0xA5A5A5A5, m_ready at c7.
- Read from 0x70000000 (unmapped) → m_ready and m_err at c1, m_spo=0, err_addr=0x70000000, err_cause=01.
- Slave ready held at 0 with TIMEOUT_CYC=8 and the macro defined → DONE after 8 WAIT cycles, m_err pulse, cause 10. With the macro undefined → still waiting after 1000 cycles.
- Second fault while err_valid=1 → m_err pulses but err_addr is unchanged. err_clr together with a new fault → the new address is captured.
- rst asserted during WAIT → next cycle IDLE, m_ready=1, no strobes, err_valid=0.
